xgmii_link_fault_monitor: RTL and testbench



---
 rtl/xgmii_pkg.sv | 15 +
 rtl/xgmii_fault_col_decode.sv | 28 ++
 rtl/xgmii_link_fault_monitor.sv | 164 ++++++++++++++++
 tb/tb_xgmii_link_fault_monitor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII receive-side constants and the link fault status encoding.
package xgmii_pkg;

    localparam logic [7:0] SEQ_OS       = 8'h9C;
    localparam logic [7:0] IDLE         = 8'h07;
    localparam logic [7:0] FAULT_LOCAL  = 8'h01;
    localparam logic [7:0] FAULT_REMOTE = 8'h02;

    typedef enum logic [1:0] {
        LF_OK     = 2'b00,
        LF_LOCAL  = 2'b01,
        LF_REMOTE = 2'b10
    } link_fault_t;

endpackage

// File: rtl/xgmii_fault_col_decode.sv
// Classifies one 32-bit XGMII column as a local/remote fault ordered set or not.
module xgmii_fault_col_decode
    import xgmii_pkg::*;
(
    input  logic [31:0] col_d_i,
    input  logic [3:0]  col_c_i,
    output logic        is_seq_o,
    output link_fault_t fault_type_o
);

    logic hdr_ok;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        is_seq_o     = 1'b0;
        fault_type_o = LF_OK;
        hdr_ok       = (col_c_i == 4'b0001) && (col_d_i[7:0] == SEQ_OS) &&
                       (col_d_i[23:8] == 16'h0000);
        if (hdr_ok && (col_d_i[31:24] == FAULT_LOCAL)) begin
            is_seq_o     = 1'b1;
            fault_type_o = LF_LOCAL;
        end else if (hdr_ok && (col_d_i[31:24] == FAULT_REMOTE)) begin
            is_seq_o     = 1'b1;
            fault_type_o = LF_REMOTE;
        end
    end

endmodule

// File: rtl/xgmii_link_fault_monitor.sv
// RS link fault monitor over two XGMII columns per cycle, with debounced link_up.
// Define LINK_FAULT_STATS_EN to build the saturating fault/link-down statistics counters.
module xgmii_link_fault_monitor
    import xgmii_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int SET_COUNT     = 4,
    parameter int CLEAR_COLUMNS = 128,
    parameter int UP_DEBOUNCE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] xgmii_rxd,
    input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
    input  logic                  rx_block_lock,
    input  logic                  rx_high_ber,
    output logic [1:0]            link_fault,
    output logic                  fault_change,
    output logic                  link_up,
    output logic [15:0]           stat_local_cnt,
    output logic [15:0]           stat_remote_cnt,
    output logic [15:0]           stat_down_cnt
);

    localparam int SEQ_W = $clog2(SET_COUNT + 1);
    localparam int COL_W = $clog2(CLEAR_COLUMNS + 1);
    localparam int DEB_W = $clog2(UP_DEBOUNCE + 1);

    localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(SET_COUNT);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(CLEAR_COLUMNS);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(UP_DEBOUNCE);

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [COL_W-1:0] col;
        link_fault_t      last;
        link_fault_t      fault;
    } mon_state_t;

    mon_state_t       st_q, st_d, st_mid;
    logic             fault_change_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             link_up_q, link_up_d;
    logic             healthy;

    logic        col0_is_seq, col1_is_seq;
    link_fault_t col0_type, col1_type;

    xgmii_fault_col_decode u_col0 (
        .col_d_i      (xgmii_rxd[31:0]),
        .col_c_i      (xgmii_rxc[3:0]),
        .is_seq_o     (col0_is_seq),
        .fault_type_o (col0_type)
    );

    xgmii_fault_col_decode u_col1 (
        .col_d_i      (xgmii_rxd[DATA_WIDTH-1:32]),
        .col_c_i      (xgmii_rxc[CTRL_WIDTH-1:4]),
        .is_seq_o     (col1_is_seq),
        .fault_type_o (col1_type)
    );

    // One column's worth of the fault sequence / clear-window state machine.
    function automatic mon_state_t step_col(input mon_state_t s, input logic is_seq,
                                            input link_fault_t t);
        mon_state_t n;
        n = s;
        if (is_seq) begin
            if ((t == s.last) && (s.col < COL_MAX))
                n.seq = (s.seq < SEQ_MAX) ? s.seq + SEQ_W'(1) : SEQ_MAX;
            else
                n.seq = SEQ_W'(1);
            n.last = t;
            n.col  = '0;
            if (n.seq == SEQ_MAX) n.fault = t;
        end else if (s.col < COL_MAX) begin
            n.col = s.col + COL_W'(1);
            if (n.col == COL_MAX) begin
                n.fault = LF_OK;
                n.seq   = '0;
            end
        end
        return n;
    endfunction

    always_comb begin
        st_d   = st_q;
        st_mid = st_q;
        if (!rx_block_lock) begin
            st_d.fault = LF_LOCAL;
            st_d.seq   = '0;
            st_d.col   = '0;
        end else begin
            // NOTE: blocking assignments chain the columns so column 1 sees column 0's result.
            st_mid = step_col(st_q, col0_is_seq, col0_type);
            st_d   = step_col(st_mid, col1_is_seq, col1_type);
        end
    end

    always_comb begin
        healthy   = (st_q.fault == LF_OK) && rx_block_lock && !rx_high_ber;
        deb_cnt_d = deb_cnt_q;
        link_up_d = link_up_q;
        if (!healthy) begin
            deb_cnt_d = '0;
            link_up_d = 1'b0;
        end else if (deb_cnt_q < DEB_MAX) begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
            if (deb_cnt_d == DEB_MAX) link_up_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q           <= '{seq: '0, col: COL_MAX, last: LF_OK, fault: LF_LOCAL};
            fault_change_q <= 1'b0;
            deb_cnt_q      <= '0;
            link_up_q      <= 1'b0;
        end else begin
            st_q           <= st_d;
            fault_change_q <= (st_d.fault != st_q.fault);
            deb_cnt_q      <= deb_cnt_d;
            link_up_q      <= link_up_d;
        end
    end

    assign link_fault   = st_q.fault;
    assign fault_change = fault_change_q;
    assign link_up      = link_up_q;

`ifdef LINK_FAULT_STATS_EN
    logic [15:0] stat_local_q, stat_remote_q, stat_down_q;
    logic        local_entry, remote_entry, down_edge;

    assign local_entry  = (st_d.fault == LF_LOCAL) && (st_q.fault != LF_LOCAL);
    assign remote_entry = (st_d.fault == LF_REMOTE) && (st_q.fault != LF_REMOTE);
    assign down_edge    = link_up_q && !link_up_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_local_q  <= '0;
            stat_remote_q <= '0;
            stat_down_q   <= '0;
        end else begin
            if (local_entry && (stat_local_q != 16'hFFFF))
                stat_local_q <= stat_local_q + 16'd1;
            if (remote_entry && (stat_remote_q != 16'hFFFF))
                stat_remote_q <= stat_remote_q + 16'd1;
            if (down_edge && (stat_down_q != 16'hFFFF))
                stat_down_q <= stat_down_q + 16'd1;
        end
    end

    assign stat_local_cnt  = stat_local_q;
    assign stat_remote_cnt = stat_remote_q;
    assign stat_down_cnt   = stat_down_q;
`else
    assign stat_local_cnt  = '0;
    assign stat_remote_cnt = '0;
    assign stat_down_cnt   = '0;
`endif

endmodule

// File: tb/tb_xgmii_link_fault_monitor.sv
// Self-checking bench: table vectors, hand corner sequences and a random run against a model.
`timescale 1ns/1ps
module tb_xgmii_link_fault_monitor;
    import xgmii_pkg::*;

    localparam int SET_C   = 4;
    localparam int CLEAR_C = 128;
    localparam int UP_DEB  = 1024;
`ifdef LINK_FAULT_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    localparam logic [31:0] COL_L = {FAULT_LOCAL, 8'h00, 8'h00, SEQ_OS};
    localparam logic [31:0] COL_R = {FAULT_REMOTE, 8'h00, 8'h00, SEQ_OS};
    localparam logic [31:0] COL_I = {IDLE, IDLE, IDLE, IDLE};

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        rx_block_lock;
    logic        rx_high_ber;
    logic [1:0]  link_fault;
    logic        fault_change;
    logic        link_up;
    logic [15:0] stat_local_cnt, stat_remote_cnt, stat_down_cnt;

    always #5 clk = ~clk;

    xgmii_link_fault_monitor #(
        .DATA_WIDTH    (64),
        .SET_COUNT     (SET_C),
        .CLEAR_COLUMNS (CLEAR_C),
        .UP_DEBOUNCE   (UP_DEB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .xgmii_rxd       (xgmii_rxd),
        .xgmii_rxc       (xgmii_rxc),
        .rx_block_lock   (rx_block_lock),
        .rx_high_ber     (rx_high_ber),
        .link_fault      (link_fault),
        .fault_change    (fault_change),
        .link_up         (link_up),
        .stat_local_cnt  (stat_local_cnt),
        .stat_remote_cnt (stat_remote_cnt),
        .stat_down_cnt   (stat_down_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, plain integers (fault: 0 ok, 1 local, 2 remote).
    int m_seq, m_col, m_last, m_fault, m_change, m_streak, m_up, m_loc, m_rem, m_down;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int col_kind(input logic [31:0] d, input logic [3:0] c);
        if (c != 4'b0001 || d[7:0] != SEQ_OS || d[15:8] != 8'h00 || d[23:16] != 8'h00) return 0;
        if (d[31:24] == FAULT_LOCAL) return 1;
        if (d[31:24] == FAULT_REMOTE) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_seq = 0; m_col = CLEAR_C; m_last = 0; m_fault = 1; m_change = 0;
        m_streak = 0; m_up = 0; m_loc = 0; m_rem = 0; m_down = 0;
    endtask

    task automatic model_step(input logic [63:0] d, input logic [7:0] c, input bit lock,
                              input bit ber);
        int prev_fault = m_fault;
        int prev_up    = m_up;
        bit healthy    = (m_fault == 0) && lock && !ber;
        int kinds[$];
        if (!lock) begin
            m_fault = 1; m_seq = 0; m_col = 0;
        end else begin
            kinds.push_back(col_kind(d[31:0], c[3:0]));
            kinds.push_back(col_kind(d[63:32], c[7:4]));
            foreach (kinds[i]) begin
                if (kinds[i] != 0) begin
                    m_seq  = (kinds[i] == m_last && m_col < CLEAR_C) ? imin(m_seq + 1, SET_C) : 1;
                    m_last = kinds[i];
                    m_col  = 0;
                    if (m_seq == SET_C) m_fault = kinds[i];
                end else if (m_col < CLEAR_C) begin
                    m_col++;
                    if (m_col == CLEAR_C) begin m_fault = 0; m_seq = 0; end
                end
            end
        end
        m_change = (m_fault != prev_fault) ? 1 : 0;
        m_streak = healthy ? m_streak + 1 : 0;
        m_up     = (m_streak >= UP_DEB) ? 1 : 0;
        if (m_change == 1 && m_fault == 1) m_loc = imin(m_loc + 1, 65535);
        if (m_change == 1 && m_fault == 2) m_rem = imin(m_rem + 1, 65535);
        if (prev_up == 1 && m_up == 0) m_down = imin(m_down + 1, 65535);
    endtask

    // Drive one cycle, advance the model at the edge, compare 1 ns later.
    task automatic cycle(input logic [63:0] d, input logic [7:0] c, input bit lock,
                         input bit ber, input bit r);
        xgmii_rxd = d; xgmii_rxc = c; rx_block_lock = lock; rx_high_ber = ber; rst = r;
        @(posedge clk);
        if (r) model_reset();
        else model_step(d, c, lock, ber);
        #1;
        check("model_fault", link_fault, m_fault);
        check("model_change", fault_change, m_change);
        check("model_link_up", link_up, m_up);
        check("model_stat_local", stat_local_cnt, STATS_ON ? m_loc : 0);
        check("model_stat_remote", stat_remote_cnt, STATS_ON ? m_rem : 0);
        check("model_stat_down", stat_down_cnt, STATS_ON ? m_down : 0);
    endtask

    // Column kinds: 0 idle, 1 local sequence, 2 remote sequence. Result is {ctrl, data}.
    function automatic logic [35:0] col_of(input int k);
        case (k)
            1:       return {4'b0001, COL_L};
            2:       return {4'b0001, COL_R};
            default: return {4'hF, COL_I};
        endcase
    endfunction

    task automatic cyc_k(input int k0, input int k1, input bit lock, input bit ber);
        logic [35:0] a = col_of(k0);
        logic [35:0] b = col_of(k1);
        cycle({b[31:0], a[31:0]}, {b[35:32], a[35:32]}, lock, ber, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fault"}, link_fault, 2'b01);
        check({tag, "_change"}, fault_change, 1'b0);
        check({tag, "_link_up"}, link_up, 1'b0);
        check({tag, "_stat_local"}, stat_local_cnt, 16'd0);
        check({tag, "_stat_remote"}, stat_remote_cnt, 16'd0);
        check({tag, "_stat_down"}, stat_down_cnt, 16'd0);
    endtask

    // Lock low for a cycle, then idle until the fault clears and link_up debounces.
    task automatic bring_up(input string tag);
        int n = 0;
        cyc_k(0, 0, 1'b0, 1'b0);
        while (link_fault !== 2'b00 && n < 200) begin cyc_k(0, 0, 1'b1, 1'b0); n++; end
        check({tag, "_clear_cycles"}, n, CLEAR_C / 2);
        check({tag, "_clear_pulse"}, fault_change, 1'b1);
        n = 0;
        while (link_up !== 1'b1 && n < 2000) begin cyc_k(0, 0, 1'b1, 1'b0); n++; end
        check({tag, "_up_cycles"}, n, UP_DEB);
    endtask

    function automatic logic [35:0] rand_col(input int mode);
        int p = $urandom_range(0, 15);
        logic [35:0] col;
        case (mode)
            0: col = (p == 0) ? {4'($urandom), 32'($urandom)} : col_of(0);
            1: col = (p < 12) ? col_of(1) : col_of(0);
            2: col = (p < 12) ? col_of(2) : col_of(0);
            default: begin
                if (p < 5)       col = col_of(1);
                else if (p < 10) col = col_of(2);
                else if (p < 13) col = col_of(0);
                else if (p < 14) col = {4'($urandom), 32'($urandom)};
                else             col = col_of(1) ^ (36'd1 << $urandom_range(0, 35));
            end
        endcase
        return col;
    endfunction

    task automatic rand_cycle(input int mode);
        logic [35:0] a = rand_col(mode);
        logic [35:0] b = rand_col(mode);
        bit lock = ($urandom_range(0, 47) != 0);
        bit ber  = ($urandom_range(0, 31) == 0);
        bit r    = ($urandom_range(0, 1499) == 0);
        cycle({b[31:0], a[31:0]}, {b[35:32], a[35:32]}, lock, ber, r);
    endtask

    typedef struct {
        int         k0;
        int         k1;
        int         rep;
        logic [1:0] fault;
        logic       change;
        logic       up;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Table starts from link up, fault OK, clear window saturated.
        vecs.push_back('{1, 0, 3,  2'b00, 1'b0, 1'b1});  // three local sequences
        vecs.push_back('{1, 0, 1,  2'b01, 1'b1, 1'b1});  // fourth declares local fault
        vecs.push_back('{0, 0, 1,  2'b01, 1'b0, 1'b0});  // link_up drops
        vecs.push_back('{2, 2, 1,  2'b01, 1'b0, 1'b0});  // two remote sequences
        vecs.push_back('{2, 2, 1,  2'b10, 1'b1, 1'b0});  // four remote sequences
        vecs.push_back('{0, 0, 63, 2'b10, 1'b0, 1'b0});  // 126 clear columns
        vecs.push_back('{0, 0, 1,  2'b00, 1'b1, 1'b0});  // 128th clears the fault
        for (int i = 0; i < 8; i++)                      // alternating L,R,L,R...
            vecs.push_back('{(i % 2 == 0) ? 1 : 2, 0, 1, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1, 0, 3,  2'b00, 1'b0, 1'b0});  // three local sequences
        vecs.push_back('{0, 0, 63, 2'b00, 1'b0, 1'b0});  // 127 columns: window still open
        vecs.push_back('{1, 0, 1,  2'b01, 1'b1, 1'b0});  // fourth counts, fault

        xgmii_rxd = {COL_I, COL_I}; xgmii_rxc = 8'hFF;
        rx_block_lock = 1'b1; rx_high_ber = 1'b0; rst = 1'b1;
        model_reset();

        cycle({COL_I, COL_I}, 8'hFF, 1'b1, 1'b0, 1'b1);
        cycle({COL_I, COL_I}, 8'hFF, 1'b1, 1'b0, 1'b1);
        check_reset_values("reset");

        bring_up("initial");

        foreach (vecs[v]) begin
            for (int r = 0; r < vecs[v].rep; r++) cyc_k(vecs[v].k0, vecs[v].k1, 1'b1, 1'b0);
            check($sformatf("vec%0d_fault", v), link_fault, vecs[v].fault);
            check($sformatf("vec%0d_change", v), fault_change, vecs[v].change);
            check($sformatf("vec%0d_link_up", v), link_up, vecs[v].up);
        end

        // Block lock lost for one cycle while the link is up.
        bring_up("relock");
        cyc_k(0, 0, 1'b0, 1'b0);
        check("lockdrop_fault", link_fault, 2'b01);
        check("lockdrop_change", fault_change, 1'b1);
        check("lockdrop_link_up", link_up, 1'b0);
        check("lockdrop_stat_local", stat_local_cnt, STATS_ON ? 3 : 0);
        check("lockdrop_stat_remote", stat_remote_cnt, STATS_ON ? 1 : 0);
        check("lockdrop_stat_down", stat_down_cnt, STATS_ON ? 2 : 0);

        // Reset after three remote sequences discards the partial count.
        for (int i = 0; i < 3; i++) cyc_k(2, 0, 1'b1, 1'b0);
        cycle({COL_I, COL_I}, 8'hFF, 1'b1, 1'b0, 1'b1);
        check_reset_values("midrst");
        cyc_k(2, 0, 1'b1, 1'b0);
        check("midrst_one_more_fault", link_fault, 2'b01);
        check("midrst_one_more_change", fault_change, 1'b0);
        for (int i = 0; i < 3; i++) cyc_k(2, 0, 1'b1, 1'b0);
        check("midrst_four_fault", link_fault, 2'b10);
        check("midrst_four_change", fault_change, 1'b1);

        // Randomised segments: idle runs, typed bursts and mixed noise.
        for (int seg = 0; seg < 150; seg++) begin
            int mode = $urandom_range(0, 3);
            int len  = (mode == 0) ? $urandom_range(20, 140) : $urandom_range(1, 10);
            for (int i = 0; i < len; i++) rand_cycle(mode);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
